text_console_ctrl: RTL
======================

TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 The module SHALL have parameter COLS, default 70, meaning character columns per row.
REQ-002 The module SHALL have parameter ROWS, default 30, meaning character rows per screen.
REQ-003 The module SHALL have port pclk, input, 1 bit, meaning the single 25 MHz clock; all state changes on its rising edge.
REQ-004 The module SHALL have port resetn, input, 1 bit, meaning reset; asynchronous, active-low.
REQ-005 The module SHALL have port ch_valid, input, 1 bit, meaning a character byte is offered.
REQ-006 The module SHALL have port ch_data, input, 8 bits, meaning the ASCII byte offered.
REQ-007 The module SHALL have port ch_ready, output, 1 bit, meaning the controller accepts ch_data this cycle.
REQ-008 The module SHALL have port scan_valid, input, 1 bit, meaning the display is in its active region (scanout owns the VRAM).
REQ-009 The module SHALL have ports scan_x and scan_y, input, 7 bits and 5 bits, meaning the scanout character cell being displayed.
REQ-010 The module SHALL have port vram_addr, output, 12 bits, meaning the single-port VRAM address.
REQ-011 The module SHALL have port vram_we, output, 1 bit, meaning the VRAM write strobe.
REQ-012 The module SHALL have port vram_wdata, output, 8 bits, meaning the VRAM write data.
REQ-013 The module SHALL have ports cur_x and cur_y, output, 7 bits and 5 bits, meaning the cursor position.
REQ-014 The module SHALL have port busy, output, 1 bit, meaning the controller is in WRITE or CLEAR.

Function
REQ-015 The VRAM address for cell (x,y) SHALL be y*COLS+x, computed at 12-bit width, range 0..COLS*ROWS-1 (0..2099).
REQ-016 Arbitration: while scan_valid=1, vram_addr SHALL equal scan_y*COLS+scan_x combinationally and vram_we SHALL be 0; scanout always has priority.
REQ-017 The controller SHALL drive vram_we=1 only in cycles with scan_valid=0; pending writes stall, without loss, while scan_valid=1.
REQ-018 The FSM states SHALL be IDLE, WRITE and CLEAR.
REQ-019 In IDLE, ch_ready SHALL be 1; ch_ready SHALL be 0 in WRITE and CLEAR.
REQ-020 A byte SHALL be accepted on a cycle with ch_valid=1 and ch_ready=1.
REQ-021 Printable byte 0x20..0x7E: latch the byte and the cursor address, then IDLE->WRITE.
REQ-022 Byte 0x0A (newline): cur_x SHALL become 0 and cur_y SHALL become cur_y+1, with no write; remain in IDLE.
REQ-023 Byte 0x08 (backspace) with cur_x>0: cur_x SHALL become cur_x-1, latch 0x20 at the new cursor address, then IDLE->WRITE.
REQ-024 Byte 0x08 with cur_x=0: no action.
REQ-025 Byte 0x0C (form feed): clear counter SHALL be set to 0, then IDLE->CLEAR.
REQ-026 All other bytes SHALL be accepted and discarded.
REQ-027 WRITE: on the first cycle with scan_valid=0, the controller SHALL drive vram_we=1 with the latched address and data, then go to IDLE.
REQ-028 After a printable write, cur_x SHALL advance by 1.
REQ-029 If cur_x reaches COLS, cur_x SHALL become 0 and cur_y SHALL become cur_y+1.
REQ-030 Backspace SHALL NOT advance the cursor.
REQ-031 cur_y wrap: an increment from ROWS-1 SHALL yield 0; no scrolling.
REQ-032 CLEAR: on each cycle with scan_valid=0, the controller SHALL write 0x20 to the address equal to the clear counter and then increment the counter.
REQ-033 CLEAR SHALL pause, counter held, while scan_valid=1.
REQ-034 After writing address COLS*ROWS-1, cur_x and cur_y SHALL become 0 and the FSM SHALL go CLEAR->IDLE.
REQ-035 When not scanning and IDLE, vram_addr SHALL equal the cursor address, with vram_we=0 and vram_wdata=0x20.
REQ-036 busy SHALL be 1 exactly when the state is WRITE or CLEAR.

Reset
REQ-037 When resetn=0, the state SHALL become IDLE, cur_x=0, cur_y=0, the clear counter SHALL become 0 and the latched data SHALL become 0x20, immediately and independent of pclk.
REQ-038 During reset, ch_ready SHALL be 0, vram_we SHALL be 0 and busy SHALL be 0.
REQ-039 Reset asserted mid-WRITE or mid-CLEAR SHALL abandon the operation with no further writes; VRAM contents are not restored.
REQ-040 After resetn deasserts, ch_ready SHALL be 1 from the first rising edge.

Verification
REQ-041 Bench SHALL apply: scan_valid=0, send 'A' (0x41) at cursor (0,0) -> next cycle vram_we=1, addr=0, wdata=0x41; then cur_x=1, ch_ready=1.
REQ-042 Bench SHALL apply: cursor (69,5), send 0x42 -> write addr 419; cursor becomes (0,6).
REQ-043 Bench SHALL apply: cursor (10,29), send 0x0A -> cursor (0,0) with no vram_we pulse.
REQ-044 Bench SHALL apply: scan_valid=1 held 20 cycles during a pending WRITE -> vram_we=0 and vram_addr tracks scan_x/scan_y throughout; the write occurs on the first cycle with scan_valid=0.
REQ-045 Bench SHALL apply: send 0x0C with scan_valid toggling -> exactly 2100 writes of 0x20, addresses 0..2099, each once and in order; busy falls after the last write; cursor (0,0).
REQ-046 Bench SHALL apply: cursor (0,3), send 0x08 -> no change; then cursor (4,3), send 0x08 -> cursor (3,3) and write of 0x20 at addr 213.

Source files
------------

// File: rtl/text_console_ctrl.sv
// Character console write controller: turns a byte stream into VRAM writes
// on a single-port VRAM shared with scanout, which always wins the port.
module text_console_ctrl #(
   parameter int COLS = 70,
   parameter int ROWS = 30
) (
   input  logic        pclk,
   input  logic        resetn,
   input  logic        ch_valid,
   input  logic [7:0]  ch_data,
   output logic        ch_ready,
   input  logic        scan_valid,
   input  logic [6:0]  scan_x,
   input  logic [4:0]  scan_y,
   output logic [11:0] vram_addr,
   output logic        vram_we,
   output logic [7:0]  vram_wdata,
   output logic [6:0]  cur_x,
   output logic [4:0]  cur_y,
   output logic        busy
);

   // state   | meaning
   // S_IDLE  | accepting bytes; VRAM address parked on the cursor cell
   // S_WRITE | one latched character write waiting for a non-scan cycle
   // S_CLEAR | filling every cell with a space, stalled by scanout
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_CLEAR = 2'd2
   } state_t;

   localparam int unsigned CELLS     = COLS * ROWS;
   localparam logic [11:0] LAST_ADDR = 12'(CELLS - 1);
   localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
   localparam logic [7:0]  CH_SPACE  = 8'h20;
   localparam logic [7:0]  CH_BS     = 8'h08;
   localparam logic [7:0]  CH_LF     = 8'h0A;
   localparam logic [7:0]  CH_FF     = 8'h0C;

   function automatic logic [11:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
      return (12'(y) * 12'(COLS)) + 12'(x);
   endfunction

   state_t      r_state;
   state_t      w_state_nxt;
   logic [6:0]  r_cur_x;
   logic [4:0]  r_cur_y;
   logic [11:0] r_lat_addr;
   logic [7:0]  r_lat_data;
   logic        r_lat_adv;
   logic [11:0] r_clr_cnt;

   logic        w_accept;
   logic        w_printable;
   logic        w_is_bs;
   logic        w_bs_act;
   logic [11:0] w_cur_addr;
   logic [11:0] w_bs_addr;
   logic [11:0] w_scan_addr;
   logic [4:0]  w_row_inc;
   logic        w_clr_last;

   assign ch_ready    = resetn && (r_state == S_IDLE);
   assign w_accept    = ch_valid && ch_ready;
   assign w_printable = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
   assign w_is_bs     = (ch_data == CH_BS);
   assign w_bs_act    = w_is_bs && (r_cur_x != 7'd0);
   assign w_cur_addr  = cell_addr(r_cur_x, r_cur_y);
   assign w_bs_addr   = cell_addr(r_cur_x - 7'd1, r_cur_y);
   assign w_scan_addr = cell_addr(scan_x, scan_y);
   assign w_row_inc   = (r_cur_y == LAST_ROW) ? 5'd0 : (r_cur_y + 5'd1);
   assign w_clr_last  = (r_clr_cnt == LAST_ADDR);

   assign cur_x = r_cur_x;
   assign cur_y = r_cur_y;
   assign busy  = (r_state != S_IDLE);

   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      vram_we     = 1'b0;
      vram_addr   = w_cur_addr;
      vram_wdata  = CH_SPACE;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_printable || w_bs_act) begin
                  w_state_nxt = S_WRITE;
               end else if (ch_data == CH_FF) begin
                  w_state_nxt = S_CLEAR;
               end
            end
         end
         S_WRITE: begin
            vram_addr  = r_lat_addr;
            vram_wdata = r_lat_data;
            if (!scan_valid) begin
               vram_we     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_CLEAR: begin
            vram_addr = r_clr_cnt;
            if (!scan_valid) begin
               vram_we = 1'b1;
               if (w_clr_last) begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // Scanout owns the port whenever it is in the active region.
      if (scan_valid) begin
         vram_addr = w_scan_addr;
         vram_we   = 1'b0;
      end
   end

   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         r_cur_x    <= 7'd0;
         r_cur_y    <= 5'd0;
         r_lat_addr <= 12'd0;
         r_lat_data <= CH_SPACE;
         r_lat_adv  <= 1'b0;
         r_clr_cnt  <= 12'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_printable) begin
                     r_lat_addr <= w_cur_addr;
                     r_lat_data <= ch_data;
                     r_lat_adv  <= 1'b1;
                  end else if (ch_data == CH_LF) begin
                     r_cur_x <= 7'd0;
                     r_cur_y <= w_row_inc;
                  end else if (w_bs_act) begin
                     r_cur_x    <= r_cur_x - 7'd1;
                     r_lat_addr <= w_bs_addr;
                     r_lat_data <= CH_SPACE;
                     r_lat_adv  <= 1'b0;
                  end else if (ch_data == CH_FF) begin
                     r_clr_cnt <= 12'd0;
                  end
               end
            end
            S_WRITE: begin
               // Backspace already moved the cursor when it was accepted.
               if (!scan_valid && r_lat_adv) begin
                  if (r_cur_x == LAST_COL) begin
                     r_cur_x <= 7'd0;
                     r_cur_y <= w_row_inc;
                  end else begin
                     r_cur_x <= r_cur_x + 7'd1;
                  end
               end
            end
            S_CLEAR: begin
               if (!scan_valid) begin
                  if (w_clr_last) begin
                     r_cur_x   <= 7'd0;
                     r_cur_y   <= 5'd0;
                     r_clr_cnt <= 12'd0;
                  end else begin
                     r_clr_cnt <= r_clr_cnt + 12'd1;
                  end
               end
            end
            default: begin
               r_lat_adv <= 1'b0;
            end
         endcase
      end
   end

endmodule
